// File: rtl/popcount_stream.sv
// Sequential ones/zeros counter: examines CHUNK bits of a latched word per clock and
// reports the per-word count plus a saturating running total over a valid/ready pair.
module popcount_stream #(
    parameter  int WIDTH = 16,
    parameter  int CHUNK = 4,
    parameter  int ACC_W = 16,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] I,
    input  logic             MODE,
    input  logic             ACC,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [CNT_W-1:0] NUMBER,
    output logic [ACC_W-1:0] TOTAL,
    output logic             SAT
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int SW    = ACC_W + 1;

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("popcount_stream: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t                      state;
    logic [N-1:0][CHUNK-1:0]     w;
    logic                        acc_l;
    logic [CNT_W-1:0]            partial;
    logic [IDX_W-1:0]            idx;
    logic [CHUNK-1:0]            cur;
    logic [CNT_W-1:0]            pc;
    logic [CNT_W-1:0]            nxt;
    logic [ACC_W-1:0]            base;
    logic [SW-1:0]               sum;

    // A single-chunk word has nothing to select between.
    generate
        if (N == 1) begin : g_one
            assign cur = w[0];
        end else begin : g_many
            assign cur = w[idx];
        end
    endgenerate

    always_comb begin
        pc = '0;
        for (int b = 0; b < CHUNK; b++) pc = pc + CNT_W'(cur[b]);
    end

    assign nxt  = partial + pc;
    assign base = acc_l ? TOTAL : '0;
    // One extra bit holds the carry that flags overflow before clamping.
    assign sum  = {1'b0, base} + SW'(nxt);

    assign IN_READY  = (state == IDLE);
    assign OUT_VALID = (state == DONE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            w       <= '0;
            acc_l   <= 1'b0;
            partial <= '0;
            idx     <= '0;
            NUMBER  <= '0;
            TOTAL   <= '0;
            SAT     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (IN_VALID) begin
                    w       <= MODE ? ~I : I;
                    acc_l   <= ACC;
                    partial <= '0;
                    idx     <= '0;
                    state   <= COUNT;
                end
                COUNT: begin
                    partial <= nxt;
                    idx     <= idx + IDX_W'(1);
                    if (idx == IDX_W'(N - 1)) begin
                        NUMBER <= nxt;
                        TOTAL  <= sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
                        SAT    <= (acc_l & SAT) | sum[ACC_W];
                        state  <= DONE;
                    end
                end
                DONE: if (OUT_READY) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_popcount_stream.sv
// Directed bench for popcount_stream: default build, a 5-bit-total build for saturation,
// and a CHUNK=WIDTH build for the single-cycle boundary, all driven by the same stimulus.
module tb_popcount_stream;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, in_valid = 1'b0, mode = 1'b0, acc = 1'b0, out_ready = 1'b0;
    logic [15:0] i = '0;

    logic        ir_a, ov_a, sat_a, ir_b, ov_b, sat_b, ir_c, ov_c, sat_c;
    logic [4:0]  num_a, num_b, num_c;
    logic [15:0] tot_a, tot_c;
    logic [4:0]  tot_b;

    int tests = 0, fails = 0;
    int lat_c = -1;

    popcount_stream #(.WIDTH(16), .CHUNK(4), .ACC_W(16)) dut_a (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(ir_a), .I(i), .MODE(mode),
        .ACC(acc), .OUT_VALID(ov_a), .OUT_READY(out_ready), .NUMBER(num_a), .TOTAL(tot_a),
        .SAT(sat_a));

    popcount_stream #(.WIDTH(16), .CHUNK(4), .ACC_W(5)) dut_b (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(ir_b), .I(i), .MODE(mode),
        .ACC(acc), .OUT_VALID(ov_b), .OUT_READY(out_ready), .NUMBER(num_b), .TOTAL(tot_b),
        .SAT(sat_b));

    popcount_stream #(.WIDTH(16), .CHUNK(16), .ACC_W(16)) dut_c (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(ir_c), .I(i), .MODE(mode),
        .ACC(acc), .OUT_VALID(ov_c), .OUT_READY(out_ready), .NUMBER(num_c), .TOTAL(tot_c),
        .SAT(sat_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake one word, then wait (bounded) for the default build's result.
    task automatic send(input logic [15:0] w, input logic m, input logic a);
        int lat;
        in_valid = 1'b1; i = w; mode = m; acc = a;
        tick();
        in_valid = 1'b0; i = 16'($urandom); mode = 1'($urandom); acc = 1'($urandom);
        lat = 0; lat_c = -1;
        while (!ov_a && lat < 20) begin
            chk("in_ready_busy", {31'b0, ir_a}, 32'd0);
            tick();
            lat++;
            if (ov_c && lat_c < 0) lat_c = lat;
        end
        chk("latency_n4", lat, 4);
        chk("latency_n1", lat_c, 1);
        chk("in_ready_done", {31'b0, ir_a}, 32'd0);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("idle_after_ack", {31'b0, ir_a}, 32'd1);
        chk("ov_after_ack", {31'b0, ov_a}, 32'd0);
    endtask

    task automatic word(input string tag, input logic [15:0] w, input logic m, input logic a,
                        input int en, input int eta, input logic esa, input int etb,
                        input logic esb);
        send(w, m, a);
        chk({tag, "_num"}, num_a, en);
        chk({tag, "_tot"}, tot_a, eta);
        chk({tag, "_sat"}, sat_a, esa);
        chk({tag, "_num_c"}, num_c, en);
        chk({tag, "_tot_c"}, tot_c, eta);
        chk({tag, "_tot_b"}, tot_b, etb);
        chk({tag, "_sat_b"}, sat_b, esb);
        release_result();
    endtask

    initial begin
        bit seen_ov;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_in_ready", ir_a, 1);
        chk("rst_out_valid", ov_a, 0);
        chk("rst_number", num_a, 0);
        chk("rst_total", tot_a, 0);
        chk("rst_sat", sat_a, 0);

        // Basic count, latency, ready behaviour
        word("t1_ffff", 16'hFFFF, 1'b0, 1'b0, 16, 16, 1'b0, 16, 1'b0);

        // Ones and zeros counting
        word("t2_a5a5_ones",  16'hA5A5, 1'b0, 1'b0, 8,  8,  1'b0, 8,  1'b0);
        word("t2_a5a5_zeros", 16'hA5A5, 1'b1, 1'b0, 8,  8,  1'b0, 8,  1'b0);
        word("t2_8001",       16'h8001, 1'b0, 1'b0, 2,  2,  1'b0, 2,  1'b0);
        word("t2_0000_zeros", 16'h0000, 1'b1, 1'b0, 16, 16, 1'b0, 16, 1'b0);

        // Accumulation and restart
        word("t3_ffff", 16'hFFFF, 1'b0, 1'b0, 16, 16, 1'b0, 16, 1'b0);
        word("t3_00ff", 16'h00FF, 1'b0, 1'b1, 8,  24, 1'b0, 24, 1'b0);
        word("t3_000f", 16'h000F, 1'b0, 1'b1, 4,  28, 1'b0, 28, 1'b0);
        word("t3_0003", 16'h0003, 1'b0, 1'b0, 2,  2,  1'b0, 2,  1'b0);

        // Backpressure: result held, inputs ignored
        send(16'h00F0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            in_valid = k[0];
            i = 16'($urandom);
            tick();
            chk("t4_num_hold", num_a, 4);
            chk("t4_tot_hold", tot_a, 4);
            chk("t4_in_ready", ir_a, 0);
            chk("t4_out_valid", ov_a, 1);
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t4_idle_next", ir_a, 1);
        chk("t4_ov_low", ov_a, 0);
        in_valid = 1'b0;
        tick();
        chk("t4_no_accept", ir_a, 1);
        chk("t4_num_kept", num_a, 4);

        // Saturation on the 5-bit total build
        word("t5_ffff",   16'hFFFF, 1'b0, 1'b0, 16, 16, 1'b0, 16, 1'b0);
        word("t5_ffff_a", 16'hFFFF, 1'b0, 1'b1, 16, 32, 1'b0, 31, 1'b1);
        word("t5_ffff_b", 16'hFFFF, 1'b0, 1'b1, 16, 48, 1'b0, 31, 1'b1);
        word("t5_0001",   16'h0001, 1'b0, 1'b0, 1,  1,  1'b0, 1,  1'b0);

        // Reset during the second COUNT cycle abandons the word
        in_valid = 1'b1; i = 16'hFFFF; mode = 1'b0; acc = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_in_ready", ir_a, 1);
        chk("t6_out_valid", ov_a, 0);
        chk("t6_number", num_a, 0);
        chk("t6_total", tot_a, 0);
        chk("t6_sat", sat_a, 0);
        chk("t6_total_b", tot_b, 0);
        chk("t6_ov_c", ov_c, 0);
        seen_ov = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (ov_a) seen_ov = 1'b1;
        end
        chk("t6_no_result", seen_ov, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
